// File: rtl/pipelined_instruction_decoder.sv
// Registered Hack instruction decoder with jump resolution, squash and perf counters.
// Latency: instruction accepted at edge N is presented from cycle N+1.
// Backpressure: ready drops on execute stall or taken jump; no skid buffer.
module pipelined_instruction_decoder #(
    parameter int DATA_WIDTH      = 16,
    parameter int COUNT_WIDTH     = 32,
    parameter bit STRICT_C_PREFIX = 1'b1
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [DATA_WIDTH-1:0]  i_Instruction,
    input  logic                   i_Instr_Valid,
    output logic                   o_Instr_Ready,
    input  logic                   i_Exec_Ready,
    input  logic                   i_ALU_Zero,
    input  logic                   i_ALU_Neg,
    output logic                   o_Valid,
    output logic                   o_Is_C_Instruction,
    output logic                   o_Illegal,
    output logic [DATA_WIDTH-2:0]  o_A_Value,
    output logic                   o_ALU_Src_Memory,
    output logic                   o_ALU_Zero_X,
    output logic                   o_ALU_Negate_X,
    output logic                   o_ALU_Zero_Y,
    output logic                   o_ALU_Negate_Y,
    output logic                   o_ALU_Function,
    output logic                   o_ALU_Negate_Out,
    output logic                   o_Write_A,
    output logic                   o_Write_D,
    output logic                   o_Write_Memory,
    output logic                   o_PC_Load,
    output logic                   o_PC_Inc,
    output logic                   o_Flush,
    output logic [COUNT_WIDTH-1:0] o_Retired_Count,
    output logic [COUNT_WIDTH-1:0] o_Jump_Count
);

    logic                   valid_q;
    logic                   is_c_q;
    logic                   illegal_q;
    logic [DATA_WIDTH-2:0]  a_value_q;
    logic [6:0]             alu_q;
    logic [2:0]             dest_q;
    logic [2:0]             jump_q;
    logic [COUNT_WIDTH-1:0] retired_q;
    logic [COUNT_WIDTH-1:0] jumps_q;

    logic in_is_c;
    logic in_illegal;
    logic in_legal_c;
    logic legal_c;
    logic xfer;
    logic cond;
    logic taken;
    logic ready;
    logic acc;

    // Decode of the incoming word, evaluated only when it is captured.
    always_comb begin
        in_is_c    = i_Instruction[DATA_WIDTH-1];
        in_illegal = in_is_c & STRICT_C_PREFIX & ~(&i_Instruction[DATA_WIDTH-2:13]);
        in_legal_c = in_is_c & ~in_illegal;
    end

    always_comb begin
        legal_c = is_c_q & ~illegal_q;
        xfer    = ~i_Reset & valid_q & i_Exec_Ready;
        cond    = (jump_q[2] & i_ALU_Neg) | (jump_q[1] & i_ALU_Zero) |
                  (jump_q[0] & ~i_ALU_Neg & ~i_ALU_Zero);
        taken   = xfer & legal_c & cond;
        // A taken jump closes the door so the wrong-path word is never captured.
        ready   = ~i_Reset & (~valid_q | (i_Exec_Ready & ~taken));
        acc     = i_Instr_Valid & ready;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            valid_q   <= 1'b0;
            is_c_q    <= 1'b0;
            illegal_q <= 1'b0;
            a_value_q <= '0;
            alu_q     <= '0;
            dest_q    <= '0;
            jump_q    <= '0;
            retired_q <= '0;
            jumps_q   <= '0;
        end else begin
            if (taken) begin
                valid_q <= 1'b0;
            end else if (acc) begin
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end

            if (acc) begin
                is_c_q    <= in_is_c;
                illegal_q <= in_illegal;
                a_value_q <= in_is_c ? '0 : i_Instruction[DATA_WIDTH-2:0];
                alu_q     <= in_legal_c ? i_Instruction[12:6] : 7'd0;
                dest_q    <= in_legal_c ? i_Instruction[5:3]  : 3'd0;
                jump_q    <= in_legal_c ? i_Instruction[2:0]  : 3'd0;
            end

            if (xfer & ~illegal_q) begin
                retired_q <= retired_q + COUNT_WIDTH'(1);
            end
            if (taken) begin
                jumps_q <= jumps_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        o_Instr_Ready      = ready;
        o_Valid            = valid_q;
        o_Is_C_Instruction = is_c_q;
        o_Illegal          = illegal_q;
        o_A_Value          = a_value_q;
        o_ALU_Src_Memory   = alu_q[6];
        o_ALU_Zero_X       = alu_q[5];
        o_ALU_Negate_X     = alu_q[4];
        o_ALU_Zero_Y       = alu_q[3];
        o_ALU_Negate_Y     = alu_q[2];
        o_ALU_Function     = alu_q[1];
        o_ALU_Negate_Out   = alu_q[0];
        // An A-instruction always loads the A register with its literal.
        o_Write_A          = xfer & (~is_c_q | (legal_c & dest_q[2]));
        o_Write_D          = xfer & legal_c & dest_q[1];
        o_Write_Memory     = xfer & legal_c & dest_q[0];
        o_PC_Load          = taken;
        o_PC_Inc           = xfer & ~taken;
        o_Flush            = taken;
        o_Retired_Count    = retired_q;
        o_Jump_Count       = jumps_q;
    end

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Directed table-driven bench for pipelined_instruction_decoder plus parameter variants.
module tb_pipelined_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0;
    logic [23:0] instr24 = 24'h7FFFFF;
    logic        ivld = 1'b0;
    logic        erdy = 1'b0;
    logic        zr = 1'b0;
    logic        ng = 1'b0;

    logic        rdy, vld, isc, ill;
    logic [14:0] aval;
    logic        asrc, azx, anx, azy, any, af, ano;
    logic        wa, wd, wm, pcl, pci, fl;
    logic [31:0] ret_cnt, jmp_cnt;

    wire  [15:0] n_bits;
    wire  [14:0] n_aval;
    wire  [31:0] n_ret, n_jmp;
    wire  [15:0] c_bits;
    wire  [14:0] c_aval;
    wire  [3:0]  c_ret, c_jmp;
    wire  [15:0] w_bits;
    wire  [22:0] w_aval;
    wire  [31:0] w_ret, w_jmp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_instruction_decoder dut (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(instr), .i_Instr_Valid(ivld),
        .o_Instr_Ready(rdy), .i_Exec_Ready(erdy), .i_ALU_Zero(zr), .i_ALU_Neg(ng),
        .o_Valid(vld), .o_Is_C_Instruction(isc), .o_Illegal(ill), .o_A_Value(aval),
        .o_ALU_Src_Memory(asrc), .o_ALU_Zero_X(azx), .o_ALU_Negate_X(anx),
        .o_ALU_Zero_Y(azy), .o_ALU_Negate_Y(any), .o_ALU_Function(af),
        .o_ALU_Negate_Out(ano), .o_Write_A(wa), .o_Write_D(wd), .o_Write_Memory(wm),
        .o_PC_Load(pcl), .o_PC_Inc(pci), .o_Flush(fl),
        .o_Retired_Count(ret_cnt), .o_Jump_Count(jmp_cnt)
    );

    pipelined_instruction_decoder #(.STRICT_C_PREFIX(1'b0)) dut_ns (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(instr), .i_Instr_Valid(ivld),
        .o_Instr_Ready(n_bits[0]), .i_Exec_Ready(erdy), .i_ALU_Zero(zr), .i_ALU_Neg(ng),
        .o_Valid(n_bits[1]), .o_Is_C_Instruction(n_bits[2]), .o_Illegal(n_bits[3]),
        .o_A_Value(n_aval), .o_ALU_Src_Memory(n_bits[4]), .o_ALU_Zero_X(n_bits[5]),
        .o_ALU_Negate_X(n_bits[6]), .o_ALU_Zero_Y(n_bits[7]), .o_ALU_Negate_Y(n_bits[8]),
        .o_ALU_Function(n_bits[9]), .o_ALU_Negate_Out(n_bits[10]), .o_Write_A(n_bits[11]),
        .o_Write_D(n_bits[12]), .o_Write_Memory(n_bits[13]), .o_PC_Load(n_bits[14]),
        .o_PC_Inc(n_bits[15]), .o_Flush(),
        .o_Retired_Count(n_ret), .o_Jump_Count(n_jmp)
    );

    pipelined_instruction_decoder #(.COUNT_WIDTH(4)) dut_c4 (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(instr), .i_Instr_Valid(ivld),
        .o_Instr_Ready(c_bits[0]), .i_Exec_Ready(erdy), .i_ALU_Zero(zr), .i_ALU_Neg(ng),
        .o_Valid(c_bits[1]), .o_Is_C_Instruction(c_bits[2]), .o_Illegal(c_bits[3]),
        .o_A_Value(c_aval), .o_ALU_Src_Memory(c_bits[4]), .o_ALU_Zero_X(c_bits[5]),
        .o_ALU_Negate_X(c_bits[6]), .o_ALU_Zero_Y(c_bits[7]), .o_ALU_Negate_Y(c_bits[8]),
        .o_ALU_Function(c_bits[9]), .o_ALU_Negate_Out(c_bits[10]), .o_Write_A(c_bits[11]),
        .o_Write_D(c_bits[12]), .o_Write_Memory(c_bits[13]), .o_PC_Load(c_bits[14]),
        .o_PC_Inc(c_bits[15]), .o_Flush(),
        .o_Retired_Count(c_ret), .o_Jump_Count(c_jmp)
    );

    pipelined_instruction_decoder #(.DATA_WIDTH(24)) dut_w24 (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(instr24), .i_Instr_Valid(ivld),
        .o_Instr_Ready(w_bits[0]), .i_Exec_Ready(erdy), .i_ALU_Zero(zr), .i_ALU_Neg(ng),
        .o_Valid(w_bits[1]), .o_Is_C_Instruction(w_bits[2]), .o_Illegal(w_bits[3]),
        .o_A_Value(w_aval), .o_ALU_Src_Memory(w_bits[4]), .o_ALU_Zero_X(w_bits[5]),
        .o_ALU_Negate_X(w_bits[6]), .o_ALU_Zero_Y(w_bits[7]), .o_ALU_Negate_Y(w_bits[8]),
        .o_ALU_Function(w_bits[9]), .o_ALU_Negate_Out(w_bits[10]), .o_Write_A(w_bits[11]),
        .o_Write_D(w_bits[12]), .o_Write_Memory(w_bits[13]), .o_PC_Load(w_bits[14]),
        .o_PC_Inc(w_bits[15]), .o_Flush(),
        .o_Retired_Count(w_ret), .o_Jump_Count(w_jmp)
    );

    // strb = {ready, valid, write_a, write_d, write_m, pc_load, pc_inc, flush}
    typedef struct {
        logic [15:0] instr;
        logic [3:0]  vezn;
        logic [7:0]  strb;
        logic [1:0]  ci;
        logic [6:0]  alu;
        logic [14:0] aval;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [15:0] i, input logic [3:0] vezn,
                                input logic [7:0] strb, input logic [1:0] ci,
                                input logic [6:0] alu, input logic [14:0] av);
        vec_t r;
        r.instr = i; r.vezn = vezn; r.strb = strb; r.ci = ci; r.alu = alu; r.aval = av;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] strobes();
        return {rdy, vld, wa, wd, wm, pcl, pci, fl};
    endfunction

    initial begin
        // Stream of four legal instructions, back to back.
        tbl.push_back(mk(16'h007B, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'hEC10, 4'b1100, 8'b11100010, 2'b00, 7'h00, 15'h7B));
        tbl.push_back(mk(16'hE090, 4'b1100, 8'b11010010, 2'b10, 7'h30, 15'h0));
        tbl.push_back(mk(16'hE308, 4'b1100, 8'b11010010, 2'b10, 7'h02, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b11001010, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        // JGT with flags 00 (taken), 10 and 01 (not taken).
        tbl.push_back(mk(16'hE301, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b01000101, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'hE301, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0110, 8'b11000010, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'hE301, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0101, 8'b11000010, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        // 0;JMP with a wrong-path word offered in the taken cycle.
        tbl.push_back(mk(16'hEA87, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'hEC10, 4'b1100, 8'b01000101, 2'b10, 7'h2A, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        // Three-cycle stall on M=D.
        tbl.push_back(mk(16'hE308, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0000, 8'b01000000, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0000, 8'b01000000, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0000, 8'b01000000, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b11001010, 2'b10, 7'h0C, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        // Malformed C prefix.
        tbl.push_back(mk(16'hA000, 4'b1100, 8'b10000000, 2'b00, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b11000010, 2'b11, 7'h00, 15'h0));
        tbl.push_back(mk(16'h0000, 4'b0100, 8'b10000000, 2'b00, 7'h00, 15'h0));

        rst = 1'b1; ivld = 1'b1; erdy = 1'b1;
        tick();
        tick();
        chk("reset_strobes", 32'(strobes()), 32'h00);
        rst = 1'b0; ivld = 1'b0;
        #1;
        chk("post_reset_strobes", 32'(strobes()), 32'h80);
        chk("post_reset_retired", ret_cnt, 32'd0);
        chk("post_reset_jumps", jmp_cnt, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            instr = tbl[i].instr;
            {ivld, erdy, zr, ng} = tbl[i].vezn;
            #1;
            chk($sformatf("row%0d_strobes", i), 32'(strobes()), 32'(tbl[i].strb));
            if (tbl[i].strb[6])
                chk($sformatf("row%0d_fields", i),
                    32'({isc, ill, asrc, azx, anx, azy, any, af, ano, aval}),
                    32'({tbl[i].ci, tbl[i].alu, tbl[i].aval}));
            tick();
        end

        chk("retired_after_table", ret_cnt, 32'd9);
        chk("jumps_after_table", jmp_cnt, 32'd2);
        chk("c4_retired_after_table", 32'(c_ret), 32'd9);
        chk("ns_A000_legal", 32'({n_bits[2], n_bits[3]}), 32'b10);
        chk("ns_retired_after_table", n_ret, 32'd10);

        // Reset asserted while an instruction is stalled.
        instr = 16'hE308; ivld = 1'b1; erdy = 1'b1; zr = 1'b0; ng = 1'b0;
        tick();
        ivld = 1'b0; erdy = 1'b0;
        #1;
        chk("stall_before_reset", 32'(strobes()), 32'h40);
        tick();
        rst = 1'b1; erdy = 1'b1; ivld = 1'b1;
        #1;
        chk("strobes_in_reset", 32'({rdy, wa, wd, wm, pcl, pci, fl}), 32'h0);
        tick();
        rst = 1'b0; ivld = 1'b0;
        #1;
        chk("reset_dropped_held", 32'({rdy, vld}), 32'b10);
        chk("reset_retired_zero", ret_cnt, 32'd0);
        chk("reset_c4_zero", 32'(c_ret), 32'd0);

        // Seventeen A-instructions to wrap the 4-bit counter.
        for (int k = 0; k < 17; k++) begin
            instr = 16'(k + 1); ivld = 1'b1; erdy = 1'b1;
            #1;
            if (k == 5) begin
                chk("stream_write_a", 32'({vld, wa, pci}), 32'b111);
                chk("stream_a_value", 32'(aval), 32'd5);
                chk("w24_a_value", 32'(w_aval), 32'h7FFFFF);
                chk("w24_is_a", 32'({w_bits[1], w_bits[2], w_bits[11]}), 32'b101);
            end
            tick();
        end
        ivld = 1'b0;
        tick();
        chk("retired_17", ret_cnt, 32'd17);
        chk("c4_wrap", 32'(c_ret), 32'd1);
        chk("w24_retired_17", w_ret, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
